// File: rtl/dmem_sort_checker.sv
// dmem_sort_checker
//   Post-halt result checker for the single_cycle_mips data memory. After a
//   start pulse it reads COUNT consecutive words starting at BASE_WORD, one per
//   clock, and checks that every adjacent pair is non-increasing (unsigned).
//   It reports pass/fail, a saturating violation count and the index of the
//   first violating pair.
//
//   Optional feature macro: DMEM_CHECKSUM_EN
//     When defined, a rotate-xor checksum of the scanned words is produced on
//     the checksum port (valid together with done). When undefined, the port
//     and its register do not exist.
module dmem_sort_checker #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int BASE_WORD = 32,
  parameter int COUNT     = 96,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err
`ifdef DMEM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0]  ALL_ONES  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  IDX_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  IDX_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(COUNT - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

`ifdef DMEM_CHECKSUM_EN
  // Rotate the running checksum left by one and fold in the new word.
  function automatic logic [DATA_W-1:0] csum_step(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] word);
    csum_step = {acc[DATA_W-2:0], acc[DATA_W-1]} ^ word;
  endfunction
`endif

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  idx_q,     idx_d;
  logic [DATA_W-1:0] prev_q,    prev_d;
  logic [CNT_W-1:0]  err_q,     err_d;
  logic [CNT_W-1:0]  first_q,   first_d;
  logic              done_q,    done_d;
  logic              pass_q,    pass_d;
  logic              rd_en_q,   rd_en_d;
  logic              busy_q,    busy_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
`ifdef DMEM_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q,    csum_d;
`endif

  // Next-state logic: start handling, per-word pair check and scan termination.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    err_d     = err_q;
    first_d   = first_q;
    done_d    = done_q;
    pass_d    = pass_q;
    rd_en_d   = rd_en_q;
    busy_d    = busy_q;
    rd_addr_d = rd_addr_q;
`ifdef DMEM_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Clear previous results and present the first read address now,
          // so the first word is captured on the very next edge.
          state_d   = ST_SCAN;
          idx_d     = IDX_ZERO;
          err_d     = IDX_ZERO;
          first_d   = ALL_ONES;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
          rd_addr_d = BASE_ADDR;
`ifdef DMEM_CHECKSUM_EN
          csum_d    = DATA_ZERO;
`endif
        end else begin
          state_d = state_q;
        end
      end

      ST_SCAN: begin
        prev_d = rd_data;
`ifdef DMEM_CHECKSUM_EN
        csum_d = csum_step(csum_q, rd_data);
`endif
        // Word 0 has no predecessor; from word 1 on, a rising step is a violation.
        if ((idx_q != IDX_ZERO) && (prev_q < rd_data)) begin
          if (err_q != ALL_ONES) begin
            err_d = err_q + IDX_ONE;
          end else begin
            err_d = err_q;
          end
          if (first_q == ALL_ONES) begin
            first_d = idx_q - IDX_ONE;
          end else begin
            first_d = first_q;
          end
        end else begin
          err_d = err_q;
        end

        if (idx_q == LAST_IDX) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          pass_d    = (err_d == IDX_ZERO);
          rd_en_d   = 1'b0;
          busy_d    = 1'b0;
          rd_addr_d = ADDR_ZERO;
        end else begin
          idx_d     = idx_q + IDX_ONE;
          rd_addr_d = BASE_ADDR + ADDR_W'(idx_q + IDX_ONE);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        rd_en_d   = 1'b0;
        busy_d    = 1'b0;
        rd_addr_d = ADDR_ZERO;
      end
    endcase
  end

  // State and result registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= IDX_ZERO;
      prev_q    <= DATA_ZERO;
      err_q     <= IDX_ZERO;
      first_q   <= ALL_ONES;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      rd_addr_q <= ADDR_ZERO;
`ifdef DMEM_CHECKSUM_EN
      csum_q    <= DATA_ZERO;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      err_q     <= err_d;
      first_q   <= first_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
`ifdef DMEM_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign first_err = first_q;
`ifdef DMEM_CHECKSUM_EN
  assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_dmem_sort_checker.sv
// Testbench for dmem_sort_checker: scoreboard of expected scan results,
// filled by the stimulus from a behavioural model of the memory window and
// drained by a monitor that also follows the read-address sequence.
module tb_dmem_sort_checker;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int BASE   = 32;
  localparam int COUNT  = 96;
  localparam int CNT_W  = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  first_err;
`ifdef DMEM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic [DATA_W-1:0] mem [0:255];
  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  dmem_sort_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_WORD(BASE), .COUNT(COUNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err(first_err)
`ifdef DMEM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  typedef struct {
    logic              pass;
    logic [CNT_W-1:0]  err;
    logic [CNT_W-1:0]  first;
    logic [DATA_W-1:0] csum;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: walk the window as plain integers, count rising steps.
  function automatic exp_t model();
    exp_t              e;
    int                errs  = 0;
    int                first = -1;
    logic [DATA_W-1:0] c     = '0;
    for (int i = 0; i < COUNT; i++) begin
      c = {c[DATA_W-2:0], c[DATA_W-1]} ^ mem[BASE+i];
      if (i > 0 && mem[BASE+i-1] < mem[BASE+i]) begin
        errs++;
        if (first < 0) first = i - 1;
      end
    end
    e.pass  = (errs == 0);
    e.err   = (errs > 511) ? 9'h1FF : CNT_W'(errs);
    e.first = (first < 0) ? 9'h1FF : CNT_W'(first);
    e.csum  = c;
    return e;
  endfunction

  // Monitor: follow the address stream while busy, score results when done rises.
  int   scan_k    = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      scan_k    = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) begin
        check("rd_en_busy", 64'(rd_en), 64'd1);
        check("rd_addr_seq", 64'(rd_addr), 64'(BASE + scan_k));
        scan_k++;
      end else begin
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("latency_edges", 64'(scan_k), 64'(COUNT));
            check("pass", 64'(pass), 64'(e.pass));
            check("err_count", 64'(err_count), 64'(e.err));
            check("first_err", 64'(first_err), 64'(e.first));
            check("rd_en_done", 64'(rd_en), 64'd0);
`ifdef DMEM_CHECKSUM_EN
            check("checksum", 64'(checksum), 64'(e.csum));
`endif
          end
        end
        scan_k = 0;
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic run_scan();
    exp_q.push_back(model());
    pulse_start();
    wait_done();
  endtask

  task automatic fill_random_all();
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
  endtask

  task automatic fill_desc();
    for (int i = 0; i < COUNT; i++) mem[BASE+i] = 32'(COUNT - i);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill_random_all();
    repeat (2) @(negedge clk);
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_first", 64'(first_err), 64'h1FF);
    reset = 1'b0;
    @(negedge clk);

    // Strictly descending window.
    fill_desc();
    run_scan();

    // Swap words 10 and 11: one violation at index 10.
    fill_desc();
    mem[BASE+10] = 32'd85;
    mem[BASE+11] = 32'd86;
    run_scan();

    // All equal neighbours are legal.
    for (int i = 0; i < COUNT; i++) mem[BASE+i] = 32'hDEAD_BEEF;
    run_scan();

    // Unsigned ordering across the sign bit.
    for (int i = 0; i < COUNT; i++) mem[BASE+i] = 32'h7FFF_FF00 - 32'(i);
    mem[BASE]   = 32'h8000_0000;
    mem[BASE+1] = 32'h7FFF_FFFF;
    run_scan();

    // Violation in the last pair only.
    fill_desc();
    mem[BASE+COUNT-1] = 32'd100;
    run_scan();

    // Reset in the middle of a scan over data with many violations.
    fill_random_all();
    pulse_start();
    repeat (39) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err_count), 64'd0);
    check("midrst_rd_en", 64'(rd_en), 64'd0);
    check("midrst_first", 64'(first_err), 64'h1FF);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    run_scan();

    // Start pulse during a scan must be ignored.
    fill_random_all();
    exp_q.push_back(model());
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();

    // Random windows: fully random, and descending with a few random bumps.
    for (int r = 0; r < 3; r++) begin
      fill_random_all();
      run_scan();
    end
    for (int r = 0; r < 3; r++) begin
      fill_random_all();
      for (int i = 0; i < COUNT; i++) mem[BASE+i] = 32'(4 * (COUNT - i));
      for (int b = 0; b < 3; b++) mem[BASE + $urandom_range(COUNT-1, 0)] = $urandom_range(400, 0);
      run_scan();
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
